// File: rtl/pic_uart_rx_if.sv
// pic_uart_rx_if: serial line and receive-status bundle for pic_uart_rx.
// Ports (signals):
//   u_rx      serial line into the receiver (idle high, 8N1, LSB first)
//   rx_ready  one-cycle strobe, rx_byte holds a new good byte
//   rx_byte   last correctly framed byte
//   frame_err one-cycle strobe, stop bit sampled low
//   rx_busy   receiver is inside a frame
// Modports: slave = receiver side, master = line driver / status consumer.
interface pic_uart_rx_if;
    logic       u_rx;
    logic       rx_ready;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       rx_busy;
    modport master (output u_rx, input rx_ready, rx_byte, frame_err, rx_busy);
    modport slave (input u_rx, output rx_ready, rx_byte, frame_err, rx_busy);
endinterface

// File: rtl/pic_uart_rx.sv
// pic_uart_rx: 8N1 UART receiver with 2-flop synchronizer and mid-bit sampling.
// Ports:
//   clock    sole clock
//   reset_n  asynchronous active-low reset
//   bus      pic_uart_rx_if.slave: u_rx in; rx_ready, rx_byte, frame_err, rx_busy out
// Parameter CLKS_PER_BIT: clocks per bit, even, 4..254.
// Macro PIC_UART_RX_MAJORITY_EN: each bit decision is the 2-of-3 majority of
// the synchronized line around mid-bit, taken one clock later than the plain
// single-sample decision.
module pic_uart_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input logic          clock,
    input logic          reset_n,
    pic_uart_rx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
`ifdef PIC_UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
`else
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
`endif
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic s1, u_s, tick, bit_s, done_ok, done_bad;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shift;
`ifdef PIC_UART_RX_MAJORITY_EN
    // hist[0] is u_s one clock ago (mid), hist[1] two clocks ago (mid-1)
    logic [1:0] hist;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) hist <= 2'b11;
        else hist <= {hist[0], u_s};
    end
    assign bit_s = (hist[1] & hist[0]) | (u_s & (hist[1] | hist[0]));
`else
    assign bit_s = u_s;
`endif
    assign tick = cnt == '0;
    assign bus.rx_busy = state inside {START, DATA, STOP};
    always_comb begin
        state_n = state;
        case (state)
            WAIT_IDLE: state_n = u_s ? IDLE : WAIT_IDLE;
            IDLE:      state_n = u_s ? IDLE : START;
            START:     state_n = !tick ? START : (bit_s ? IDLE : DATA);
            DATA:      state_n = (tick && idx == 3'd7) ? STOP : DATA;
            STOP:      state_n = !tick ? STOP : (bit_s ? IDLE : WAIT_IDLE);
            default:   state_n = WAIT_IDLE;
        endcase
    end
    // Strobes are issued the clock after the stop decision so the FSM is
    // already back in IDLE and can catch an immediately following start edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1            <= 1'b1;
            u_s           <= 1'b1;
            state         <= WAIT_IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            done_ok       <= 1'b0;
            done_bad      <= 1'b0;
            bus.rx_ready  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.rx_byte   <= '0;
        end else begin
            s1            <= bus.u_rx;
            u_s           <= s1;
            state         <= state_n;
            cnt           <= (state == IDLE) ? HALF : (tick ? FULL : cnt - CW'(1));
            idx           <= (state != DATA) ? 3'd0 : (tick ? idx + 3'd1 : idx);
            shift         <= (state == DATA && tick) ? {bit_s, shift[7:1]} : shift;
            done_ok       <= state == STOP && tick && bit_s;
            done_bad      <= state == STOP && tick && !bit_s;
            bus.rx_ready  <= done_ok;
            bus.frame_err <= done_bad;
            bus.rx_byte   <= done_ok ? shift : bus.rx_byte;
        end
    end
endmodule

// File: tb/tb_pic_uart_rx.sv
// tb_pic_uart_rx: scoreboard bench for pic_uart_rx (directed frames, glitch, break, mid-frame reset).
module tb_pic_uart_rx;
    localparam int C = 8;
`ifdef PIC_UART_RX_MAJORITY_EN
    localparam int LAT = 80;
    localparam int BUSY_LIMIT = 5;
`else
    localparam int LAT = 79;
    localparam int BUSY_LIMIT = 4;
`endif
    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int busy_run = 0;
    int busy_max = 0;
    int strobes = 0;
    int s0;
    exp_t sb[$];

    pic_uart_rx_if bus ();
    pic_uart_rx #(.CLKS_PER_BIT(C)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Called at a negedge just before the start bit is driven; the strobe is
    // seen by the monitor LAT+1 negedges later.
    task automatic expect_strobe(input bit err, input logic [7:0] data);
        sb.push_back('{err, data, cyc + LAT + 1});
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
        bus.u_rx = 1'b0;
        repeat (C) @(negedge clock);
        for (int k = 0; k < 8; k++) begin
            bus.u_rx = b[k];
            if (k == glitch_bit) begin
                repeat (C / 2) @(negedge clock);
                bus.u_rx = ~b[k];
                @(negedge clock);
                bus.u_rx = b[k];
                repeat (C / 2 - 1) @(negedge clock);
            end else begin
                repeat (C) @(negedge clock);
            end
        end
        bus.u_rx = stop;
        repeat (C) @(negedge clock);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            busy_run = bus.rx_busy ? busy_run + 1 : 0;
            if (busy_run > busy_max) busy_max = busy_run;
            if (bus.rx_ready || bus.frame_err) begin
                exp_t e;
                strobes++;
                check("strobe_exclusive", int'(bus.rx_ready && bus.frame_err), 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe ready=%0b err=%0b byte=0x%h at cycle %0d",
                             bus.rx_ready, bus.frame_err, bus.rx_byte, cyc);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind_err", int'(bus.frame_err), int'(e.err));
                    check("strobe_byte", int'(bus.rx_byte), int'(e.data));
                    check("strobe_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    initial begin
        bus.u_rx = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clock);
        check("reset_rx_ready", int'(bus.rx_ready), 0);
        check("reset_frame_err", int'(bus.frame_err), 0);
        check("reset_rx_busy", int'(bus.rx_busy), 0);
        check("reset_rx_byte", int'(bus.rx_byte), 0);
        reset_n = 1'b1;
        repeat (2 * C) @(negedge clock);
        expect_strobe(1'b0, 8'h02);
        send_frame(8'h02, 1'b1, -1);
        repeat (2 * C) @(negedge clock);
        expect_strobe(1'b0, 8'h55);
        send_frame(8'h55, 1'b1, -1);
        expect_strobe(1'b0, 8'hA3);
        send_frame(8'hA3, 1'b1, -1);
        repeat (2 * C) @(negedge clock);
        busy_max = 0;
        s0 = strobes;
        bus.u_rx = 1'b0;
        repeat (3) @(negedge clock);
        bus.u_rx = 1'b1;
        repeat (4 * C) @(negedge clock);
        check("glitch_busy_within_limit", int'(busy_max <= BUSY_LIMIT), 1);
        check("glitch_no_strobe", strobes, s0);
        expect_strobe(1'b1, 8'hA3);
        send_frame(8'h05, 1'b0, -1);
        repeat (40 * C) @(negedge clock);
        check("break_single_strobe", strobes, s0 + 1);
        bus.u_rx = 1'b1;
        repeat (2 * C) @(negedge clock);
        expect_strobe(1'b0, 8'h01);
        send_frame(8'h01, 1'b1, -1);
        repeat (2 * C) @(negedge clock);
        bus.u_rx = 1'b0;
        repeat (C) @(negedge clock);
        bus.u_rx = 1'b1;
        repeat (4 * C + C / 2) @(negedge clock);
        reset_n = 1'b0;
        bus.u_rx = 1'b0;
        #1;
        check("midreset_rx_ready", int'(bus.rx_ready), 0);
        check("midreset_frame_err", int'(bus.frame_err), 0);
        check("midreset_rx_busy", int'(bus.rx_busy), 0);
        check("midreset_rx_byte", int'(bus.rx_byte), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        s0 = strobes;
        repeat (2) @(negedge clock);
        bus.u_rx = 1'b1;
        repeat (3 * C) @(negedge clock);
        check("midreset_no_strobe", strobes, s0);
        expect_strobe(1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        repeat (2 * C) @(negedge clock);
`ifdef PIC_UART_RX_MAJORITY_EN
        expect_strobe(1'b0, 8'h00);
        send_frame(8'h00, 1'b1, 2);
        repeat (2 * C) @(negedge clock);
`endif
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
